// File: rtl/game_pkg.sv
// Shared types and constants for the math game answer path.
// Includes the BCD-digit helpers used by the answer entry block.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [3:0] DIGIT_MAX               = 4'd9;
    localparam int         ANSWER_W                = 8;
    localparam int         DEBOUNCE_CYCLES_DEFAULT = 4;

    // Advance one decimal digit, wrapping 9 back to 0 with no carry out
    function automatic logic [3:0] next_digit(input logic [3:0] d);
        logic [3:0] r;
        if (d >= DIGIT_MAX) begin
            r = 4'd0;
        end else begin
            r = d + 4'd1;
        end
        return r;
    endfunction

    // tens*10 + units built from shifts; the result never exceeds 99
    function automatic logic [ANSWER_W-1:0] bcd_to_bin(input logic [3:0] tens,
                                                      input logic [3:0] units);
        logic [ANSWER_W-1:0] t;
        t = {4'd0, tens};
        return (t << 3) + (t << 1) + {4'd0, units};
    endfunction

endpackage

// File: rtl/bcd_answer_entry_if.sv
// Valid/ack handshake that carries the committed binary answer to game control.
interface bcd_answer_entry_if import game_pkg::*; ();

    logic [ANSWER_W-1:0] answer;
    logic                answer_valid;
    logic                answer_ack;

    modport master (output answer, output answer_valid, input answer_ack);
    modport slave  (input answer, input answer_valid, output answer_ack);

endinterface

// File: rtl/bcd_answer_entry_button_conditioner.sv
// Synchronizes and debounces one raw pushbutton; emits a one-cycle press
// pulse when the debounced level rises.
module button_conditioner
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

    logic             sync1_r;
    logic             sync2_r;
    logic             deb_r;
    logic [CNT_W-1:0] cnt_r;
    logic             press_r;

    // Synchronizer, debounce counter and rising-edge press pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            deb_r   <= 1'b0;
            cnt_r   <= CNT_W'(0);
            press_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            if (sync2_r == deb_r) begin
                cnt_r   <= CNT_W'(0);
                press_r <= 1'b0;
            end else if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_r   <= sync2_r;
                cnt_r   <= CNT_W'(0);
                press_r <= sync2_r;
            end else begin
                cnt_r   <= cnt_r + CNT_W'(1);
                press_r <= 1'b0;
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/bcd_answer_entry.sv
// Player answer entry: debounced buttons build two BCD digits, submit converts
// them to binary and holds the result on a valid/ack handshake.
module bcd_answer_entry
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      btn_tens_inc,
    input  logic                      btn_units_inc,
    input  logic                      btn_clear,
    input  logic                      btn_submit,
    output logic [3:0]                entry_tens,
    output logic [3:0]                entry_units,
    output logic                      entry_active,
    bcd_answer_entry_if.master        ans_if
);

    logic press_tens_s;
    logic press_units_s;
    logic press_clear_s;
    logic press_submit_s;

    state_t              state_r;
    logic [3:0]          tens_r;
    logic [3:0]          units_r;
    logic [ANSWER_W-1:0] answer_r;
    logic                valid_r;
    logic                active_r;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_tens (
        .clk(clk), .rst(rst), .raw(btn_tens_inc), .press(press_tens_s)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_units (
        .clk(clk), .rst(rst), .raw(btn_units_inc), .press(press_units_s)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clear (
        .clk(clk), .rst(rst), .raw(btn_clear), .press(press_clear_s)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_submit (
        .clk(clk), .rst(rst), .raw(btn_submit), .press(press_submit_s)
    );

    // Entry FSM with digit counters, answer register and handshake flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            tens_r   <= 4'd0;
            units_r  <= 4'd0;
            answer_r <= {ANSWER_W{1'b0}};
            valid_r  <= 1'b0;
            active_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    tens_r  <= 4'd0;
                    units_r <= 4'd0;
                    if (enable) begin
                        state_r  <= ENTRY;
                        active_r <= 1'b1;
                    end else begin
                        state_r  <= IDLE;
                        active_r <= 1'b0;
                    end
                end
                ENTRY: begin
                    if (press_clear_s) begin
                        tens_r   <= 4'd0;
                        units_r  <= 4'd0;
                        state_r  <= enable ? ENTRY : IDLE;
                        active_r <= enable;
                    end else if (press_submit_s) begin
                        answer_r <= bcd_to_bin(tens_r, units_r);
                        valid_r  <= 1'b1;
                        state_r  <= HOLD;
                        active_r <= 1'b0;
                    end else if (!enable) begin
                        tens_r   <= 4'd0;
                        units_r  <= 4'd0;
                        state_r  <= IDLE;
                        active_r <= 1'b0;
                    end else begin
                        if (press_tens_s) begin
                            tens_r <= next_digit(tens_r);
                        end else begin
                            tens_r <= tens_r;
                        end
                        if (press_units_s) begin
                            units_r <= next_digit(units_r);
                        end else begin
                            units_r <= units_r;
                        end
                    end
                end
                HOLD: begin
                    // Valid is released only by ack so a dropped enable never loses the answer
                    if (ans_if.answer_ack) begin
                        valid_r  <= 1'b0;
                        tens_r   <= 4'd0;
                        units_r  <= 4'd0;
                        state_r  <= enable ? ENTRY : IDLE;
                        active_r <= enable;
                    end else begin
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    tens_r   <= 4'd0;
                    units_r  <= 4'd0;
                    valid_r  <= 1'b0;
                    active_r <= 1'b0;
                end
            endcase
        end
    end

    assign entry_tens          = tens_r;
    assign entry_units         = units_r;
    assign entry_active        = active_r;
    assign ans_if.answer       = answer_r;
    assign ans_if.answer_valid = valid_r;

endmodule

// File: tb/tb_bcd_answer_entry.sv
// Directed self-checking bench for bcd_answer_entry with default debounce depth.
module tb_bcd_answer_entry;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [3:0] raw_btn;   // [0] tens, [1] units, [2] clear, [3] submit
    logic [3:0] entry_tens;
    logic [3:0] entry_units;
    logic       entry_active;
    int         n_checks;
    int         n_errors;

    bcd_answer_entry_if ans_if ();

    bcd_answer_entry dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .btn_tens_inc (raw_btn[0]),
        .btn_units_inc(raw_btn[1]),
        .btn_clear    (raw_btn[2]),
        .btn_submit   (raw_btn[3]),
        .entry_tens   (entry_tens),
        .entry_units  (entry_units),
        .entry_active (entry_active),
        .ans_if       (ans_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold the selected raw buttons for hi cycles, then release long enough to re-arm
    task automatic pulse(input logic [3:0] mask, input int hi);
        raw_btn = mask;
        tick(hi);
        raw_btn = 4'b0000;
        tick(8);
    endtask

    task automatic ack_once();
        ans_if.answer_ack = 1'b1;
        tick(1);
        ans_if.answer_ack = 1'b0;
    endtask

    task automatic check_digits(input string tag, input logic [3:0] t, input logic [3:0] u);
        check_val({tag, "_tens"}, {28'd0, entry_tens}, {28'd0, t});
        check_val({tag, "_units"}, {28'd0, entry_units}, {28'd0, u});
    endtask

    initial begin
        n_checks          = 0;
        n_errors          = 0;
        rst               = 1'b0;
        enable            = 1'b0;
        raw_btn           = 4'b0000;
        ans_if.answer_ack = 1'b0;
        tick(2);
        check_digits("reset", 4'd0, 4'd0);
        check_val("reset_answer", {24'd0, ans_if.answer}, 32'd0);
        check_val("reset_valid", {31'd0, ans_if.answer_valid}, 32'd0);
        check_val("reset_active", {31'd0, entry_active}, 32'd0);
        rst = 1'b1;
        tick(2);

        // 43 entry, submit, ack
        enable = 1'b1;
        tick(1);
        check_val("enter_active", {31'd0, entry_active}, 32'd1);
        for (int i = 0; i < 4; i++) pulse(4'b0001, 6);
        for (int i = 0; i < 3; i++) pulse(4'b0010, 6);
        check_digits("d43", 4'd4, 4'd3);
        pulse(4'b1000, 6);
        check_val("ans43", {24'd0, ans_if.answer}, 32'd43);
        check_val("ans43_valid", {31'd0, ans_if.answer_valid}, 32'd1);
        check_val("ans43_hold_active", {31'd0, entry_active}, 32'd0);
        ack_once();
        check_val("ack_valid", {31'd0, ans_if.answer_valid}, 32'd0);
        check_digits("ack", 4'd0, 4'd0);
        check_val("ack_active", {31'd0, entry_active}, 32'd1);
        check_val("ack_answer_kept", {24'd0, ans_if.answer}, 32'd43);

        // units wrap, tens untouched
        for (int i = 1; i <= 10; i++) begin
            pulse(4'b0010, 6);
            check_val("units_seq", {28'd0, entry_units}, i % 10);
        end
        check_val("units_wrap_tens", {28'd0, entry_tens}, 32'd0);
        for (int i = 0; i < 9; i++) pulse(4'b0001, 6);
        check_val("tens9", {28'd0, entry_tens}, 32'd9);
        pulse(4'b0001, 6);
        check_val("tens_wrap", {28'd0, entry_tens}, 32'd0);

        // Short glitch ignored, then precise press timing
        pulse(4'b0010, 2);
        check_val("glitch_units", {28'd0, entry_units}, 32'd0);
        raw_btn = 4'b0010;
        tick(6);
        check_val("edge5_units", {28'd0, entry_units}, 32'd0);
        tick(1);
        check_val("edge6_units", {28'd0, entry_units}, 32'd1);
        raw_btn = 4'b0000;
        tick(8);
        check_val("single_inc", {28'd0, entry_units}, 32'd1);

        // Clear beats submit
        pulse(4'b0100, 6);
        check_digits("cleared", 4'd0, 4'd0);
        for (int i = 0; i < 2; i++) pulse(4'b0001, 6);
        for (int i = 0; i < 5; i++) pulse(4'b0010, 6);
        check_digits("d25", 4'd2, 4'd5);
        pulse(4'b1100, 6);
        check_digits("clr_sub", 4'd0, 4'd0);
        check_val("clr_sub_valid", {31'd0, ans_if.answer_valid}, 32'd0);
        check_val("clr_sub_active", {31'd0, entry_active}, 32'd1);

        // 57, enable drops during HOLD
        for (int i = 0; i < 5; i++) pulse(4'b0001, 6);
        for (int i = 0; i < 7; i++) pulse(4'b0010, 6);
        pulse(4'b1000, 6);
        enable = 1'b0;
        tick(3);
        check_val("ans57_valid", {31'd0, ans_if.answer_valid}, 32'd1);
        check_val("ans57", {24'd0, ans_if.answer}, 32'd57);
        ack_once();
        check_val("ans57_ack_valid", {31'd0, ans_if.answer_valid}, 32'd0);
        check_val("ans57_idle_active", {31'd0, entry_active}, 32'd0);
        pulse(4'b0001, 6);
        pulse(4'b0010, 6);
        ack_once();
        check_digits("idle_press", 4'd0, 4'd0);
        check_val("idle_ack_valid", {31'd0, ans_if.answer_valid}, 32'd0);

        // Async reset in HOLD with 12
        enable = 1'b1;
        tick(1);
        pulse(4'b0001, 6);
        pulse(4'b0010, 6);
        pulse(4'b0010, 6);
        pulse(4'b1000, 6);
        check_val("ans12", {24'd0, ans_if.answer}, 32'd12);
        check_val("ans12_valid", {31'd0, ans_if.answer_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_val("arst_valid", {31'd0, ans_if.answer_valid}, 32'd0);
        check_val("arst_answer", {24'd0, ans_if.answer}, 32'd0);
        check_digits("arst", 4'd0, 4'd0);
        check_val("arst_active", {31'd0, entry_active}, 32'd0);
        tick(2);
        rst = 1'b1;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
